// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and state encoding for the SRAM port arbiter.
package sram_arb_pkg;
    localparam int SRAM_ADDR_W = 14;
    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_DEPTH  = 16384;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;
endpackage

// File: rtl/sram_port_arbiter_rr.sv
// Round-robin arbiter: grants the first request at or after the pointer, cyclically.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr;
    logic [IW-1:0] sel;
    logic          found;

    always_comb begin
        gnt   = '0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                gnt[(int'(ptr) + k) % N] = 1'b1;
                sel                      = IW'((int'(ptr) + k) % N);
                found                    = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
        end
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1W1R SRAM among NUM_PORTS writers and readers; sweeps the array after reset.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int                     NUM_PORTS = 4,
    parameter int                     SRAM_IDX  = 0,
    parameter int                     INIT_EN   = 1,
    parameter logic [SRAM_DATA_W-1:0] INIT_VAL  = 16'h0000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PORTS-1:0]               wr_req,
    input  logic [NUM_PORTS*SRAM_ADDR_W-1:0]   wr_addr,
    input  logic [NUM_PORTS*SRAM_DATA_W-1:0]   wr_data,
    output logic [NUM_PORTS-1:0]               wr_gnt,
    input  logic [NUM_PORTS-1:0]               rd_req,
    input  logic [NUM_PORTS*SRAM_ADDR_W-1:0]   rd_addr,
    output logic [NUM_PORTS-1:0]               rd_gnt,
    output logic                               rd_vld,
    output logic [$clog2(NUM_PORTS)-1:0]       rd_id,
    output logic [SRAM_DATA_W-1:0]             rd_data,
    output logic                               init_done,
    output logic                               sram_wr_en,
    output logic [SRAM_ADDR_W-1:0]             sram_wr_addr,
    output logic [SRAM_DATA_W-1:0]             sram_din,
    output logic                               sram_rd_en,
    output logic [SRAM_ADDR_W-1:0]             sram_rd_addr,
    input  logic [SRAM_DATA_W-1:0]             sram_dout,
    output logic [4:0]                         sram_idx
);
    localparam int     ID_W     = $clog2(NUM_PORTS);
    localparam state_t ST_RESET = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_t                   state, state_nxt;
    logic [SRAM_ADDR_W-1:0]   init_cnt;
    logic                     run;
    logic [NUM_PORTS-1:0]     wr_req_run, rd_req_run;
    logic [ID_W-1:0]          rd_sel;
    logic [SRAM_ADDR_W-1:0]   wr_sel_addr, rd_sel_addr;
    logic [SRAM_DATA_W-1:0]   wr_sel_data;

    // Requests only reach the arbiters in RUN and never while reset is held.
    assign run        = (state == ST_RUN) && !rst;
    assign wr_req_run = run ? wr_req : '0;
    assign rd_req_run = run ? rd_req : '0;

    rr_arbiter #(.N(NUM_PORTS)) u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req_run),
        .gnt (wr_gnt)
    );

    rr_arbiter #(.N(NUM_PORTS)) u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req_run),
        .gnt (rd_gnt)
    );

    always_comb begin
        rd_sel      = '0;
        wr_sel_addr = '0;
        wr_sel_data = '0;
        rd_sel_addr = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr_gnt[i]) begin
                wr_sel_addr = wr_addr[i*SRAM_ADDR_W +: SRAM_ADDR_W];
                wr_sel_data = wr_data[i*SRAM_DATA_W +: SRAM_DATA_W];
            end
            if (rd_gnt[i]) begin
                rd_sel      = ID_W'(i);
                rd_sel_addr = rd_addr[i*SRAM_ADDR_W +: SRAM_ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sram_wr_en   = 1'b0;
        sram_wr_addr = '0;
        sram_din     = '0;
        sram_rd_en   = 1'b0;
        sram_rd_addr = '0;
        if (!rst) begin
            case (state)
                ST_INIT: begin
                    sram_wr_en   = 1'b1;
                    sram_wr_addr = init_cnt;
                    sram_din     = INIT_VAL;
                    if (init_cnt == SRAM_ADDR_W'(SRAM_DEPTH - 1)) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    sram_wr_en   = |wr_gnt;
                    sram_wr_addr = wr_sel_addr;
                    sram_din     = wr_sel_data;
                    sram_rd_en   = |rd_gnt;
                    sram_rd_addr = rd_sel_addr;
                end
                default: state_nxt = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + SRAM_ADDR_W'(1);
            end
            init_done <= (state_nxt == ST_RUN);
        end
    end

    // Response tag tracks the SRAM's one-cycle registered read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld <= 1'b0;
            rd_id  <= '0;
        end else begin
            rd_vld <= |rd_gnt;
            if (|rd_gnt) begin
                rd_id <= rd_sel;
            end
        end
    end

    assign rd_data  = sram_dout;
    assign sram_idx = 5'(SRAM_IDX);
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized scoreboard bench for sram_port_arbiter with a behavioural SRAM and arbiter model.
module tb_sram_port_arbiter;
    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     wr_req, rd_req;
    logic [NP*14-1:0]  wr_addr, rd_addr;
    logic [NP*16-1:0]  wr_data;
    logic [NP-1:0]     wr_gnt, rd_gnt;
    logic              rd_vld;
    logic [1:0]        rd_id;
    logic [15:0]       rd_data;
    logic              init_done;
    logic              sram_wr_en, sram_rd_en;
    logic [13:0]       sram_wr_addr, sram_rd_addr;
    logic [15:0]       sram_din, sram_dout;
    logic [4:0]        sram_idx;

    sram_port_arbiter #(.NUM_PORTS(NP), .SRAM_IDX(3), .INIT_EN(1), .INIT_VAL(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_vld(rd_vld), .rd_id(rd_id), .rd_data(rd_data), .init_done(init_done),
        .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_din(sram_din),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_dout(sram_dout),
        .sram_idx(sram_idx)
    );

    always #5 clk = ~clk;

    // Behavioural 1W1R SRAM with registered, read-first output.
    logic [15:0] mem [16384];
    always @(posedge clk) begin
        if (sram_rd_en) sram_dout <= mem[sram_rd_addr];
        if (sram_wr_en) mem[sram_wr_addr] <= sram_din;
    end

    typedef struct {
        int          id;
        logic [15:0] data;
    } resp_t;

    resp_t       exp_q[$];
    logic [15:0] ref_mem [16384];
    int          wptr, rptr;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NP-1:0] req, input int ptr);
        for (int k = 0; k < NP; k++) begin
            if (req[(ptr + k) % NP]) return (ptr + k) % NP;
        end
        return -1;
    endfunction

    // One RUN cycle: drive, check grants and SRAM port, update the model.
    task automatic step(input logic [NP-1:0] wq, input logic [NP*14-1:0] wa,
                        input logic [NP*16-1:0] wd, input logic [NP-1:0] rq,
                        input logic [NP*14-1:0] ra, output int wg, output int rg);
        @(negedge clk);
        #1;
        wr_req = wq; wr_addr = wa; wr_data = wd; rd_req = rq; rd_addr = ra;
        #1;
        wg = rr_pick(wq, wptr);
        rg = rr_pick(rq, rptr);
        check("wr_gnt", 32'(wr_gnt), (wg < 0) ? 0 : (1 << wg));
        check("rd_gnt", 32'(rd_gnt), (rg < 0) ? 0 : (1 << rg));
        check("sram_wr_en", 32'(sram_wr_en), 32'(wg >= 0));
        check("sram_rd_en", 32'(sram_rd_en), 32'(rg >= 0));
        if (rg >= 0) begin
            check("sram_rd_addr", 32'(sram_rd_addr), 32'(ra[rg*14 +: 14]));
            exp_q.push_back('{id: rg, data: ref_mem[ra[rg*14 +: 14]]});
            rptr = (rg + 1) % NP;
        end
        if (wg >= 0) begin
            check("sram_wr_addr", 32'(sram_wr_addr), 32'(wa[wg*14 +: 14]));
            check("sram_din", 32'(sram_din), 32'(wd[wg*16 +: 16]));
            ref_mem[wa[wg*14 +: 14]] = wd[wg*16 +: 16];
            wptr = (wg + 1) % NP;
        end
    endtask

    // Response monitor: every valid response must match the oldest expectation.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (!rst && rd_vld) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 32'(rd_vld), 32'(0));
                end else begin
                    r = exp_q.pop_front();
                    check("rd_id", 32'(rd_id), 32'(r.id));
                    check("rd_data", 32'(rd_data), 32'(r.data));
                end
            end
        end
    end

    logic [NP-1:0]    wq, rq;
    logic [NP*14-1:0] wa, ra;
    logic [NP*16-1:0] wd;
    int               wg, rg, sweep_err;

    initial begin
        rst = 1'b1;
        wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        wptr = 0; rptr = 0;
        for (int a = 0; a < 16384; a++) ref_mem[a] = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_vld", 32'(rd_vld), 0);
        check("rst_rd_id", 32'(rd_id), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_sram_wr_en", 32'(sram_wr_en), 0);
        check("sram_idx", 32'(sram_idx), 3);

        // Requests held across the sweep must not be granted until RUN.
        wr_req = 4'b0010; wr_addr[1*14 +: 14] = 14'd9; wr_data[1*16 +: 16] = 16'hABCD;
        rd_req = 4'b0100; rd_addr[2*14 +: 14] = 14'd7;
        @(negedge clk);
        rst = 1'b0;
        sweep_err = 0;
        for (int i = 0; i < 16384; i++) begin
            #1;
            if (sram_wr_en !== 1'b1 || sram_wr_addr !== 14'(i) || sram_din !== 16'h0000 ||
                wr_gnt !== '0 || rd_gnt !== '0 || sram_rd_en !== 1'b0 || init_done !== 1'b0)
                sweep_err++;
            @(negedge clk);
        end
        check("sweep_errors", 32'(sweep_err), 0);
        #1;
        check("init_done", 32'(init_done), 1);
        #1;
        check("first_run_wr_gnt", 32'(wr_gnt), 32'h2);
        check("first_run_rd_gnt", 32'(rd_gnt), 32'h4);
        exp_q.push_back('{id: 2, data: ref_mem[7]});
        ref_mem[9] = 16'hABCD;
        wptr = 2; rptr = 3;

        // Park wr_ptr at 0, then all writers request for 8 cycles.
        step(4'b1000, '0, '0, '0, '0, wg, rg);
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, '0, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, '0, '0, wg, rg);
            check("rr_seq", 32'(wr_gnt), 32'(1 << (k % 4)));
        end

        // Write then tagged read of the same address.
        wa = '0; wd = '0; ra = '0;
        wa[2*14 +: 14] = 14'h0123; wd[2*16 +: 16] = 16'hBEEF;
        step(4'b0100, wa, wd, '0, '0, wg, rg);
        ra[3*14 +: 14] = 14'h0123;
        step('0, '0, '0, 4'b1000, ra, wg, rg);

        // Same-cycle write/read to one address returns the old data.
        wa = '0; wd = '0; ra = '0;
        wa[0 +: 14] = 14'd5; wd[0 +: 16] = 16'h1111;
        step(4'b0001, wa, wd, '0, '0, wg, rg);
        wd[0 +: 16] = 16'h2222; ra[1*14 +: 14] = 14'd5;
        step(4'b0001, wa, wd, 4'b0010, ra, wg, rg);
        step('0, '0, '0, 4'b0010, ra, wg, rg);

        // Read pointer skip: park at 1, lone port 0, then ports 1 and 3.
        step('0, '0, '0, 4'b0001, '0, wg, rg);
        step('0, '0, '0, 4'b0001, '0, wg, rg);
        check("skip_gnt0", 32'(rd_gnt), 32'h1);
        step('0, '0, '0, 4'b1010, '0, wg, rg);
        check("skip_gnt1", 32'(rd_gnt), 32'h2);
        step('0, '0, '0, 4'b1000, '0, wg, rg);
        check("skip_gnt3", 32'(rd_gnt), 32'h8);

        // Random traffic with requests held until granted.
        wq = '0; rq = '0; wa = '0; ra = '0; wd = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NP; i++) begin
                if (!wq[i] && $urandom_range(0, 1) == 1) begin
                    wq[i] = 1'b1;
                    wa[i*14 +: 14] = 14'($urandom_range(0, 15));
                    wd[i*16 +: 16] = 16'($urandom);
                end
                if (!rq[i] && $urandom_range(0, 1) == 1) begin
                    rq[i] = 1'b1;
                    ra[i*14 +: 14] = 14'($urandom_range(0, 15));
                end
            end
            step(wq, wa, wd, rq, ra, wg, rg);
            if (wg >= 0) wq[wg] = 1'b0;
            if (rg >= 0) rq[rg] = 1'b0;
        end
        step('0, '0, '0, '0, '0, wg, rg);
        step('0, '0, '0, '0, '0, wg, rg);
        check("queue_drained", 32'(exp_q.size()), 0);

        // Reset right after a read grant discards the response.
        ra = '0; ra[0 +: 14] = 14'd5;
        step('0, '0, '0, 4'b0001, ra, wg, rg);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        wr_req = 4'b1111; rd_req = 4'b1111;
        #1;
        check("mrst_rd_vld", 32'(rd_vld), 0);
        check("mrst_init_done", 32'(init_done), 0);
        check("mrst_wr_gnt", 32'(wr_gnt), 0);
        check("mrst_rd_gnt", 32'(rd_gnt), 0);
        check("mrst_sram_wr_en", 32'(sram_wr_en), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("resweep_addr", 32'(sram_wr_addr), 32'(i));
            check("resweep_en", 32'(sram_wr_en), 1);
            check("resweep_gnt", 32'({wr_gnt, rd_gnt}), 0);
            check("resweep_rd_vld", 32'(rd_vld), 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one 1W1R 16384x16 SRAM macro between NUM_PORTS write requesters and NUM_PORTS read requesters.
- Uses independent round-robin arbitration on the write and read sides.
- After reset, sweeps the whole array to INIT_VAL before granting any request.
- Returns read data one cycle after grant, tagged with the requester index.
- Sits between the packet-buffer clients and each SRAM instance; one arbiter per SRAM.

Parameters:
- NUM_PORTS, 4, number of write requesters and number of read requesters (2..16).
- SRAM_IDX, 0, constant driven on sram_idx for this instance (0..31).
- INIT_EN, 1, 1 = zero-sweep after reset; 0 = go straight to RUN.
- INIT_VAL, 16'h0000, data written during the sweep.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- wr_req  in  NUM_PORTS  per-port write request.
- wr_addr  in  NUM_PORTS*14  packed write addresses; port i at [14i+:14].
- wr_data  in  NUM_PORTS*16  packed write data.
- wr_gnt  out  NUM_PORTS  one-hot write grant, same cycle as the request.
- rd_req  in  NUM_PORTS  per-port read request.
- rd_addr  in  NUM_PORTS*14  packed read addresses.
- rd_gnt  out  NUM_PORTS  one-hot read grant, same cycle.
- rd_vld  out  1  read response valid.
- rd_id  out  $clog2(NUM_PORTS)  port index of the response.
- rd_data  out  16  response data.
- init_done  out  1  high once in RUN.
- sram_wr_en  out  1  SRAM write enable.
- sram_wr_addr  out  14  SRAM write address.
- sram_din  out  16  SRAM write data.
- sram_rd_en  out  1  SRAM read enable.
- sram_rd_addr  out  14  SRAM read address.
- sram_dout  in  16  SRAM read data; registered inside the SRAM, valid one cycle after sram_rd_en.
- sram_idx  out  5  constant SRAM_IDX.

Behaviour:
- Reset values: state=INIT (RUN if INIT_EN=0); init_cnt=0; both RR pointers=0; rd_vld=0; rd_id=0; init_done=0.
- All grant and sram_* outputs are combinational from state and requests. They are 0 while rst is high.
- INIT state:
  - sram_wr_en=1, sram_wr_addr=init_cnt, sram_din=INIT_VAL; init_cnt increments each cycle.
  - When init_cnt==16383 on a clock edge, go to RUN; init_done rises on that edge.
  - Sweep takes exactly 16384 cycles.
  - wr_gnt=0, rd_gnt=0, sram_rd_en=0. Requests are held by the requester, not queued.
- RUN state:
  - The write arbiter picks the first asserted wr_req at or after wr_ptr (cyclic) and raises that wr_gnt.
  - It drives sram_wr_en=1 with that port's addr/data.
  - Pointer update on a grant: wr_ptr <= granted+1 mod NUM_PORTS. No grant: pointer holds.
  - The read side is identical and independent, using rd_ptr, sram_rd_en and sram_rd_addr.
  - A write and a read may be granted in the same cycle.
- Handshake:
  - A request is consumed in any cycle where req & gnt.
  - A requester keeps req and its address/data stable until granted.
  - A port may request back-to-back every cycle. Starvation bound: NUM_PORTS-1 cycles of waiting.
- Read latency:
  - Read granted on edge t gives rd_vld=1 in the following cycle, with rd_id = granted port and rd_data = sram_dout (passthrough).
  - rd_vld and rd_id are registered. Fully pipelined, one response per cycle.
- Same-cycle write and read to the same address: the read returns the pre-write data (read-first). The write is visible to a read granted one cycle later.
- rst asserted mid-INIT or mid-RUN:
  - State immediately goes to INIT, counter and pointers clear, rd_vld drops to 0.
  - The in-flight response is discarded.
  - The sweep restarts from address 0 after release.

Decomposition:
- Package sram_arb_pkg: SRAM_ADDR_W=14, SRAM_DATA_W=16, SRAM_DEPTH=16384, state enum {ST_INIT, ST_RUN}.
- Sub-module rr_arbiter (params N; ports clk, rst, req, gnt, with internal pointer): instantiated twice, once for write and once for read. The parent gates its req input with state==ST_RUN.

Test Plan:
- Sweep: reset release, INIT_EN=1 -> 16384 writes of 0 to addresses 0..16383 in order; init_done=1 at cycle 16384; no grants before then. Requests held during INIT are granted on the first RUN cycle.
- Round-robin: NUM_PORTS=4, all wr_req=1 held for 8 cycles starting with wr_ptr=0 -> wr_gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Read tagging: port 2 writes 16'hBEEF to addr 14'h0123; next cycle port 3 reads 14'h0123 -> rd_vld=1 one cycle after the grant, with rd_id=3 and rd_data=16'hBEEF.
- Collision: 16'h1111 already at addr 5; write 16'h2222 to addr 5 and read addr 5 in the same cycle -> response 16'h1111. A read in the next cycle -> 16'h2222.
- Skip/pointer: rd_ptr=1, only rd_req[0] asserted -> rd_gnt=0001 and rd_ptr becomes 1. Then rd_req=1010 -> grants port 1, then port 3.
- Mid-run reset: rst pulsed the cycle after a read grant -> rd_vld stays 0, init_done=0, sweep restarts at address 0.
